// File: rtl/tdm_rectifier.sv
// Serial-to-parallel TDM frame rectifier: hunts for frame sync, shifts in one
// bit per sclk and presents each completed frame as one wide word with a strobe.
module tdm_rectifier #(
   parameter int FRAME_BITS = 256,
   parameter int MSB_FIRST  = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  sdata,
   input  logic                  sfs,
   output logic                  pvalid,
   output logic [FRAME_BITS-1:0] pdata,
   output logic                  locked,
   output logic                  frame_err,
   output logic [CNT_W-1:0]      frame_cnt,
   output logic [CNT_W-1:0]      err_cnt
);

   localparam int BCW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);

   typedef enum logic {HUNT, CAPTURE} state_t;

   state_t                r_state, w_state_nxt;
   logic [BCW-1:0]        r_bcnt, w_bcnt_nxt;
   logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
   logic [FRAME_BITS-1:0] w_base, w_shift;
   logic                  w_load, w_err;
   logic [FRAME_BITS-1:0] r_pdata;
   logic                  r_pvalid, r_ferr;
   logic [CNT_W-1:0]      r_frame_cnt, r_err_cnt;

   // A sync clears the shift base so the new frame's bit 0 enters a clean register.
   always_comb begin
      w_base  = sfs ? '0 : r_shreg;
      w_shift = (MSB_FIRST != 0) ? {w_base[FRAME_BITS-2:0], sdata}
                                 : {sdata, w_base[FRAME_BITS-1:1]};
   end

   always_ff @(posedge sclk) begin
      if (rst) r_state <= HUNT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bcnt_nxt  = r_bcnt;
      w_shreg_nxt = r_shreg;
      w_load      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         HUNT: begin
            if (sfs) begin
               w_state_nxt = CAPTURE;
               w_bcnt_nxt  = BCW'(1);
               w_shreg_nxt = w_shift;
            end
         end
         CAPTURE: begin
            w_shreg_nxt = w_shift;
            if (sfs) begin
               w_err      = 1'b1;
               w_bcnt_nxt = BCW'(1);
            end else if (r_bcnt == LAST_BIT) begin
               w_load      = 1'b1;
               w_state_nxt = HUNT;
               w_bcnt_nxt  = '0;
            end else begin
               w_bcnt_nxt = r_bcnt + BCW'(1);
            end
         end
         default: w_state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_bcnt      <= '0;
         r_shreg     <= '0;
         r_pdata     <= '0;
         r_pvalid    <= 1'b0;
         r_ferr      <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_bcnt   <= w_bcnt_nxt;
         r_shreg  <= w_shreg_nxt;
         r_pvalid <= w_load;
         r_ferr   <= w_err;
         if (w_load) begin
            r_pdata     <= w_shift;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
         if (w_err) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign pvalid    = r_pvalid;
   assign pdata     = r_pdata;
   assign locked    = (r_state == CAPTURE);
   assign frame_err = r_ferr;
   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tdm_rectifier.sv
// Directed self-checking bench for tdm_rectifier (FRAME_BITS=256, MSB_FIRST=1).
module tb_tdm_rectifier;

   localparam int FB = 256;
   localparam int CW = 16;

   logic          sclk = 1'b0;
   logic          rst, sdata, sfs;
   logic          pvalid, locked, frame_err;
   logic [FB-1:0] pdata;
   logic [CW-1:0] frame_cnt, err_cnt;

   int checks = 0;
   int errors = 0;
   logic [FB-1:0] last_pdata;

   tdm_rectifier #(.FRAME_BITS(FB), .MSB_FIRST(1), .CNT_W(CW)) dut (
      .sclk(sclk), .rst(rst), .sdata(sdata), .sfs(sfs),
      .pvalid(pvalid), .pdata(pdata), .locked(locked), .frame_err(frame_err),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   always #5 sclk = ~sclk;

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [FB-1:0] rep8(input logic [7:0] b);
      return {32{b}};
   endfunction

   // Full frame, sfs on bit 0; leaves the bench in the cycle after the last bit.
   task automatic send_frame(input string tag, input logic [FB-1:0] f, input logic exp_err);
      int bad = 0;
      for (int k = 0; k < FB; k++) begin
         sdata = f[FB-1-k];
         sfs   = (k == 0);
         tick();
         if (k == 0) chk({tag, "_ferr_at_sync"}, {255'b0, frame_err}, {255'b0, exp_err});
         else if (frame_err !== 1'b0) bad++;
         if (k < FB-1) begin
            if (pvalid !== 1'b0 || locked !== 1'b1 || pdata !== last_pdata) bad++;
         end
      end
      sfs = 1'b0;
      chk({tag, "_pvalid"}, {255'b0, pvalid}, {255'b0, 1'b1});
      chk({tag, "_pdata"}, pdata, f);
      chk({tag, "_locked_drop"}, {255'b0, locked}, '0);
      chk({tag, "_ferr_clear"}, {255'b0, frame_err}, '0);
      chk({tag, "_inframe_bad"}, FB'(bad), '0);
      last_pdata = f;
   endtask

   task automatic send_partial(input string tag, input logic [FB-1:0] f, input int n);
      int bad = 0;
      for (int k = 0; k < n; k++) begin
         sdata = f[FB-1-k];
         sfs   = (k == 0);
         tick();
         if (pvalid !== 1'b0 || frame_err !== 1'b0 || locked !== 1'b1 || pdata !== last_pdata) bad++;
      end
      sfs = 1'b0;
      chk({tag, "_partial_bad"}, FB'(bad), '0);
   endtask

   initial begin
      int bad;
      rst = 1'b1; sdata = 1'b0; sfs = 1'b0;
      last_pdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_pdata", pdata, '0);
      chk("rst_flags", {253'b0, pvalid, locked, frame_err}, '0);
      chk("rst_cnts", {224'b0, frame_cnt, err_cnt}, '0);

      // No sync: random data must never lock or produce frames
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         sdata = 1'($urandom_range(0, 1));
         tick();
         if (pvalid !== 1'b0 || locked !== 1'b0 || frame_err !== 1'b0) bad++;
      end
      chk("hunt_idle_bad", FB'(bad), '0);
      chk("hunt_idle_fcnt", FB'(frame_cnt), '0);

      send_frame("a5", rep8(8'hA5), 1'b0);
      chk("a5_fcnt", FB'(frame_cnt), FB'(1));
      tick();
      chk("a5_pvalid_one_cycle", {255'b0, pvalid}, '0);
      chk("a5_pdata_hold", pdata, rep8(8'hA5));

      // Back-to-back: next sfs lands in the pvalid cycle of the previous frame
      send_frame("b2b0", rep8(8'h3C), 1'b0);
      send_frame("b2b1", rep8(8'hFF), 1'b0);
      send_frame("b2b2", rep8(8'h00), 1'b0);
      chk("b2b_fcnt", FB'(frame_cnt), FB'(4));
      chk("b2b_ecnt", FB'(err_cnt), '0);
      tick();

      // Early sync at bit 100 aborts the partial frame
      send_partial("early", rep8(8'h55), 100);
      send_frame("early_new", {8{32'h12345678}}, 1'b1);
      chk("early_ecnt", FB'(err_cnt), FB'(1));
      chk("early_fcnt", FB'(frame_cnt), FB'(5));
      tick();

      // 37-cycle gap with garbage between frames
      send_frame("gap0", {8{32'hDEADBEEF}}, 1'b0);
      bad = 0;
      for (int i = 0; i < 37; i++) begin
         sdata = 1'($urandom_range(0, 1));
         tick();
         if (i > 0 && pvalid !== 1'b0) bad++;
         if (locked !== 1'b0 || frame_err !== 1'b0 || pdata !== last_pdata) bad++;
      end
      chk("gap_bad", FB'(bad), '0);
      send_frame("gap1", {8{32'h0F1E2D3C}}, 1'b0);
      chk("gap_fcnt", FB'(frame_cnt), FB'(7));
      chk("gap_ecnt", FB'(err_cnt), FB'(1));
      tick();

      // Reset at bit 200 discards the partial frame
      send_partial("rstmid", rep8(8'hC3), 200);
      rst = 1'b1;
      sdata = 1'b1;
      tick();
      rst = 1'b0;
      last_pdata = '0;
      chk("rstmid_pdata", pdata, '0);
      chk("rstmid_flags", {253'b0, pvalid, locked, frame_err}, '0);
      chk("rstmid_cnts", {224'b0, frame_cnt, err_cnt}, '0);
      tick();
      chk("rstmid_no_pvalid", {255'b0, pvalid}, '0);
      send_frame("post_rst", {8{32'hCAFEF00D}}, 1'b0);
      chk("post_rst_fcnt", FB'(frame_cnt), FB'(1));
      chk("post_rst_ecnt", FB'(err_cnt), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
